// File: rtl/register_file_pkg.sv
// Shared definitions for the integer register file.
// The optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
package register_file_pkg;

  localparam int WORD_W     = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int N_REGS     = 2 ** ADDR_WIDTH;

  // Clock half-period used by benches driving clk_cpu.
  localparam int HCYCL = 5;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port: selects a register from the flattened array.
// With REGFILE_BYPASS_EN defined, a write in flight to the same address is
// forwarded to the output ahead of the clock edge (never while reset is low).
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_W,
  parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH,
  parameter int N_REGS     = 2 ** ADDR_WIDTH
) (
  input  logic [N_REGS-1:0][DATA_WIDTH-1:0] regs,
  input  logic [ADDR_WIDTH-1:0]             rd_adrs,
`ifdef REGFILE_BYPASS_EN
  input  logic                              reset,
  input  logic                              wr_en,
  input  logic [ADDR_WIDTH-1:0]             wr_adrs,
  input  logic [DATA_WIDTH-1:0]             wr_data,
`endif
  output logic [DATA_WIDTH-1:0]             q
);

  logic [DATA_WIDTH-1:0] w_stored;

  assign w_stored = regs[rd_adrs];

`ifdef REGFILE_BYPASS_EN
  // Forward pending write data when it targets the register being read.
  always_comb begin
    q = w_stored;
    if (reset && wr_en && (wr_adrs == rd_adrs)) begin
      q = wr_data;
    end
  end
`else
  // Plain lookup of the stored value.
  always_comb begin
    q = w_stored;
  end
`endif

endmodule

// File: rtl/register_file.sv
// 32 x 32-bit integer register file: two combinational read ports, one
// synchronous write port, asynchronous active-low clear of every register.
// Register 0 is an ordinary writable register.
// Defining REGFILE_BYPASS_EN adds write-to-read forwarding on both ports.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_W,
  parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH,
  parameter int N_REGS     = 2 ** ADDR_WIDTH
) (
  input  logic                  clk_cpu,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rd_adrs_a,
  input  logic [ADDR_WIDTH-1:0] rd_adrs_b,
  input  logic [ADDR_WIDTH-1:0] wr_adrs,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic [DATA_WIDTH-1:0] q_b
);

  logic [N_REGS-1:0][DATA_WIDTH-1:0] r_regs;

  // Storage: clear everything on reset, otherwise capture the writeback word.
  always_ff @(posedge clk_cpu or negedge reset) begin
    if (!reset) begin
      r_regs <= '0;
    end else if (wr_en) begin
      r_regs[wr_adrs] <= wr_data;
    end
  end

  register_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .N_REGS     (N_REGS)
  ) u_port_a (
    .regs    (r_regs),
    .rd_adrs (rd_adrs_a),
`ifdef REGFILE_BYPASS_EN
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_adrs (wr_adrs),
    .wr_data (wr_data),
`endif
    .q       (q_a)
  );

  register_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .N_REGS     (N_REGS)
  ) u_port_b (
    .regs    (r_regs),
    .rd_adrs (rd_adrs_b),
`ifdef REGFILE_BYPASS_EN
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_adrs (wr_adrs),
    .wr_data (wr_data),
`endif
    .q       (q_b)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file against an array model of the
// register contents. Honours REGFILE_BYPASS_EN when defined at compile time.
module tb_register_file;
  import register_file_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_cpu = 1'b0;
  logic        reset   = 1'b0;
  logic [4:0]  rd_adrs_a = '0;
  logic [4:0]  rd_adrs_b = '0;
  logic [4:0]  wr_adrs   = '0;
  logic [31:0] wr_data   = '0;
  logic        wr_en     = 1'b0;
  logic [31:0] q_a;
  logic [31:0] q_b;

  logic [31:0] model [32];
  int n_cmp = 0;
  int n_err = 0;

  register_file dut (
    .clk_cpu   (clk_cpu),
    .reset     (reset),
    .rd_adrs_a (rd_adrs_a),
    .rd_adrs_b (rd_adrs_b),
    .wr_adrs   (wr_adrs),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .q_a       (q_a),
    .q_b       (q_b)
  );

  always #HCYCL clk_cpu = ~clk_cpu;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk_cpu);
    #1;
  endtask

  // Drive one write (or idle) cycle and apply the same effect to the model.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic en);
    wr_adrs = a;
    wr_data = d;
    wr_en   = en;
    tick();
    if (en && reset) model[a] = d;
    wr_en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    repeat (5) tick();
    reset = 1'b1;
    #1;
    for (int a = 0; a < 32; a++) begin
      rd_adrs_a = 5'(a);
      rd_adrs_b = 5'(31 - a);
      #1;
      n_cmp++;
      if (q_a !== 32'h0) begin
        n_err++;
        $display("FAIL reset_q_a addr=%0d got=%h exp=00000000", a, q_a);
      end
      n_cmp++;
      if (q_b !== 32'h0) begin
        n_err++;
        $display("FAIL reset_q_b addr=%0d got=%h exp=00000000", 31 - a, q_b);
      end
    end
  endtask

  task automatic test_seq_write;
    for (int i = 0; i < 32; i++) do_write(5'(i), 32'(i), 1'b1);
    for (int i = 0; i < 32; i++) begin
      rd_adrs_a = 5'(i);
      rd_adrs_b = 5'(i);
      #1;
      n_cmp++;
      if (q_a !== 32'(i)) begin
        n_err++;
        $display("FAIL seq_q_a addr=%0d got=%h exp=%h", i, q_a, 32'(i));
      end
      n_cmp++;
      if (q_b !== 32'(i)) begin
        n_err++;
        $display("FAIL seq_q_b addr=%0d got=%h exp=%h", i, q_b, 32'(i));
      end
    end
  endtask

  task automatic test_parallel;
    logic [31:0] v [32];
    for (int i = 0; i < 32; i++) v[i] = $urandom;
    for (int i = 0; i < 32; i++) begin
      rd_adrs_a = 5'((i + 31) % 32);
      rd_adrs_b = 5'((i + 31) % 32);
      do_write(5'(i), v[i], 1'b1);
      if (i > 0) begin
        n_cmp++;
        if (q_a !== v[i-1] || q_b !== v[i-1]) begin
          n_err++;
          $display("FAIL parallel addr=%0d got_a=%h got_b=%h exp=%h", i - 1, q_a, q_b, v[i-1]);
        end
      end
    end
    rd_adrs_a = 5'd0;
    rd_adrs_b = 5'd31;
    #1;
    n_cmp++;
    if (q_a !== v[0] || q_b !== v[31]) begin
      n_err++;
      $display("FAIL parallel_ends got0=%h exp0=%h got31=%h exp31=%h", q_a, v[0], q_b, v[31]);
    end
  endtask

  task automatic test_write_disable;
    do_write(5'd5, 32'hDEADBEEF, 1'b0);
    rd_adrs_a = 5'd5;
    rd_adrs_b = 5'd5;
    #1;
    n_cmp++;
    if (q_a !== model[5] || q_b !== model[5]) begin
      n_err++;
      $display("FAIL write_disable got_a=%h got_b=%h exp=%h", q_a, q_b, model[5]);
    end
  endtask

  task automatic test_same_addr;
    logic [31:0] exp_pre;
    do_write(5'd7, 32'h11, 1'b1);
    rd_adrs_a = 5'd7;
    rd_adrs_b = 5'd7;
    wr_adrs   = 5'd7;
    wr_data   = 32'h22;
    wr_en     = 1'b1;
    #1;
    exp_pre = BYP ? 32'h22 : 32'h11;
    n_cmp++;
    if (q_a !== exp_pre) begin
      n_err++;
      $display("FAIL same_addr_before got=%h exp=%h", q_a, exp_pre);
    end
    tick();
    model[7] = 32'h22;
    wr_en = 1'b0;
    n_cmp++;
    if (q_a !== 32'h22 || q_b !== 32'h22) begin
      n_err++;
      $display("FAIL same_addr_after got_a=%h got_b=%h exp=00000022", q_a, q_b);
    end
  endtask

  task automatic test_random;
    logic [31:0] exp_a, exp_b;
    for (int n = 0; n < 300; n++) begin
      rd_adrs_a = 5'($urandom_range(31));
      rd_adrs_b = 5'($urandom_range(31));
      wr_adrs   = (n % 5 == 0) ? rd_adrs_a : 5'($urandom_range(31));
      wr_data   = $urandom;
      wr_en     = 1'($urandom_range(1));
      #1;
      exp_a = (BYP && wr_en && wr_adrs == rd_adrs_a) ? wr_data : model[rd_adrs_a];
      exp_b = (BYP && wr_en && wr_adrs == rd_adrs_b) ? wr_data : model[rd_adrs_b];
      n_cmp++;
      if (q_a !== exp_a || q_b !== exp_b) begin
        n_err++;
        $display("FAIL rand_pre n=%0d got_a=%h exp_a=%h got_b=%h exp_b=%h", n, q_a, exp_a, q_b, exp_b);
      end
      tick();
      if (wr_en) model[wr_adrs] = wr_data;
      n_cmp++;
      if (q_a !== model[rd_adrs_a] || q_b !== model[rd_adrs_b]) begin
        n_err++;
        $display("FAIL rand_post n=%0d got_a=%h exp_a=%h got_b=%h exp_b=%h",
                 n, q_a, model[rd_adrs_a], q_b, model[rd_adrs_b]);
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic sweep_zero(input string tag);
    int bad = 0;
    for (int a = 0; a < 32; a++) begin
      rd_adrs_a = 5'(a);
      rd_adrs_b = 5'(a);
      #1;
      if (q_a !== 32'h0 || q_b !== 32'h0) begin
        bad++;
        $display("FAIL %s addr=%0d got_a=%h got_b=%h exp=00000000", tag, a, q_a, q_b);
      end
    end
    n_cmp++;
    if (bad != 0) n_err++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    d = $urandom | 32'h1;
    do_write(5'd3, 32'hA5A5_0003, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    sweep_zero("reset_mid_clear");
    wr_adrs   = 5'd3;
    wr_data   = d;
    wr_en     = 1'b1;
    rd_adrs_a = 5'd3;
    rd_adrs_b = 5'd3;
    repeat (2) tick();
    n_cmp++;
    if (q_a !== 32'h0 || q_b !== 32'h0) begin
      n_err++;
      $display("FAIL reset_write_ignored got_a=%h got_b=%h exp=00000000", q_a, q_b);
    end
    @(negedge clk_cpu);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    tick();
    model[3] = d;
    wr_en = 1'b0;
    n_cmp++;
    if (q_a !== d) begin
      n_err++;
      $display("FAIL first_write_after_reset got=%h exp=%h", q_a, d);
    end
    rd_adrs_a = 5'd4;
    #1;
    n_cmp++;
    if (q_a !== 32'h0) begin
      n_err++;
      $display("FAIL other_reg_after_reset got=%h exp=00000000", q_a);
    end
    #2;
    reset = 1'b0;
    #1;
    sweep_zero("second_reset_low");
    reset = 1'b1;
    sweep_zero("second_reset_released");
  endtask

  initial begin
    test_reset();
    test_seq_write();
    test_parallel();
    test_write_disable();
    test_same_addr();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
